// File: rtl/seq_signed_mult_core.sv
// ============================================================================
// seq_signed_mult_core : sequential shift-add multiplier, signed/unsigned,
//                        full 2*WIDTH product with optional early exit
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_signed_mult_core #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 negative
);

    localparam int               ITW         = $clog2(WIDTH);
    localparam logic [ITW-1:0]   c_ITER_LAST = ITW'(WIDTH - 1);
    localparam logic [ITW-1:0]   c_ITER_ONE  = ITW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2
    } state_t;

    state_t                r_state;
    logic [WIDTH-1:0]      r_mp;
    logic [2*WIDTH-1:0]    r_mc;
    logic [2*WIDTH-1:0]    r_acc;
    logic [ITW-1:0]        r_iter;
    logic                  r_neg_pend;

    logic [WIDTH-1:0]      w_mp_mag;
    logic [WIDTH-1:0]      w_mc_mag;
    logic [WIDTH-1:0]      w_mp_next;
    logic [2*WIDTH-1:0]    w_acc_add;
    logic                  w_last;

    // The most negative operand negates to 2^(WIDTH-1), still exact as unsigned.
    assign w_mp_mag  = (signed_mode && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
    assign w_mc_mag  = (signed_mode && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
    assign w_mp_next = r_mp >> 1;
    assign w_acc_add = r_mp[0] ? (r_acc + r_mc) : r_acc;
    assign w_last    = (r_iter == c_ITER_LAST) || (EARLY_EXIT && (w_mp_next == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mp       <= '0;
            r_mc       <= '0;
            r_acc      <= '0;
            r_iter     <= '0;
            r_neg_pend <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            product    <= '0;
            negative   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mp       <= w_mp_mag;
                        r_mc       <= {{WIDTH{1'b0}}, w_mc_mag};
                        r_acc      <= '0;
                        r_iter     <= '0;
                        r_neg_pend <= signed_mode & (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
                        busy       <= 1'b1;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc  <= w_acc_add;
                    r_mp   <= w_mp_next;
                    r_mc   <= r_mc << 1;
                    r_iter <= r_iter + c_ITER_ONE;
                    if (w_last) begin
                        r_state <= S_SIGN;
                    end
                end
                S_SIGN: begin
                    product  <= r_neg_pend ? -r_acc : r_acc;
                    // A zero magnitude is never reported as negative.
                    negative <= r_neg_pend & (r_acc != '0);
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_signed_mult_core.sv
// ============================================================================
// tb_seq_signed_mult_core : scoreboard bench for seq_signed_mult_core
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_signed_mult_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start8, sm8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, neg8;
    logic [15:0] prod8;
    logic        busy8n, done8n, neg8n;
    logic [15:0] prod8n;
    logic        start16, sm16;
    logic [15:0] a16, b16;
    logic        busy16, done16, neg16;
    logic [31:0] prod16;

    seq_signed_mult_core #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .multiplier(a8), .multiplicand(b8),
        .busy(busy8), .done(done8), .product(prod8), .negative(neg8));

    seq_signed_mult_core #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut8n (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .multiplier(a8), .multiplicand(b8),
        .busy(busy8n), .done(done8n), .product(prod8n), .negative(neg8n));

    seq_signed_mult_core #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .multiplier(a16), .multiplicand(b16),
        .busy(busy16), .done(done16), .product(prod16), .negative(neg16));

    typedef struct {
        logic [31:0] prod;
        logic        neg;
        int          lat;
        longint      acc;
    } exp_t;

    exp_t   q8[$];
    exp_t   q8n[$];
    exp_t   q16[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got done pulse expected none", name);
    endtask

    // Monitors: each done pulse pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done8) begin
            if (q8.size() == 0) unexpected("dut8 extra done");
            else begin
                e = q8.pop_front();
                check("dut8 product", {16'h0, prod8}, e.prod);
                check("dut8 negative", {31'h0, neg8}, {31'h0, e.neg});
                check("dut8 latency", 32'(cyc - e.acc), 32'(e.lat));
                check("dut8 busy at done", {31'h0, busy8}, 32'h0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done8n) begin
            if (q8n.size() == 0) unexpected("dut8n extra done");
            else begin
                e = q8n.pop_front();
                check("dut8n product", {16'h0, prod8n}, e.prod);
                check("dut8n negative", {31'h0, neg8n}, {31'h0, e.neg});
                check("dut8n latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done16) begin
            if (q16.size() == 0) unexpected("dut16 extra done");
            else begin
                e = q16.pop_front();
                check("dut16 product", prod16, e.prod);
                check("dut16 negative", {31'h0, neg16}, {31'h0, e.neg});
                check("dut16 latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    // Early-exit latency: calc cycles = max(1, msb index + 1), plus one edge.
    function automatic int lat_ee(input longint v);
        longint m;
        int     k;
        m = (v < 0) ? -v : v;
        k = -1;
        for (int i = 0; i < 32; i++) if (m[i]) k = i;
        return ((k < 1) ? 1 : k + 1) + 1;
    endfunction

    task automatic wait_idle8();
        int t = 0;
        @(negedge clk);
        while ((busy8 || busy8n) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut8 idle timeout: got busy expected idle");
        end
    endtask

    task automatic op8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] ep, input logic en, input int lat1);
        wait_idle8();
        start8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
        q8.push_back('{prod: {16'h0, ep}, neg: en, lat: lat1, acc: cyc + 1});
        q8n.push_back('{prod: {16'h0, ep}, neg: en, lat: 9, acc: cyc + 1});
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
    endtask

    task automatic op16(input logic sm, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] ep, input logic en, input int lat1);
        int t = 0;
        @(negedge clk);
        while (busy16 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut16 idle timeout: got busy expected idle");
        end
        start16 = 1'b1; sm16 = sm; a16 = a; b16 = b;
        q16.push_back('{prod: ep, neg: en, lat: lat1, acc: cyc + 1});
        @(negedge clk);
        start16 = 1'b0;
        a16 = 16'($urandom);
        b16 = 16'($urandom);
    endtask

    initial begin
        logic               sm;
        logic [7:0]         ra, rb;
        logic [15:0]        wa, wb;
        logic signed [15:0] p8;
        logic signed [31:0] p16;
        int                 t;

        rst = 1'b1;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        check("reset busy8", {31'h0, busy8}, 32'h0);
        check("reset done8", {31'h0, done8}, 32'h0);
        check("reset product8", {16'h0, prod8}, 32'h0);
        check("reset negative8", {31'h0, neg8}, 32'h0);
        check("reset busy16", {31'h0, busy16}, 32'h0);
        check("reset product16", prod16, 32'h0);
        rst = 1'b0;

        // Directed: signed, unsigned, extremes, zero handling.
        op8(1'b1, 8'hFD, 8'h07, 16'hFFEB, 1'b1, 3);
        op8(1'b1, 8'h80, 8'h80, 16'h4000, 1'b0, 9);
        op8(1'b1, 8'h80, 8'h7F, 16'hC080, 1'b1, 9);
        // Second start while busy must be ignored.
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b0; a8 = 8'h03; b8 = 8'h03;
        @(negedge clk);
        start8 = 1'b0;
        op8(1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 9);
        op8(1'b0, 8'h00, 8'h9C, 16'h0000, 1'b0, 2);
        op8(1'b1, 8'hFB, 8'h00, 16'h0000, 1'b0, 4);
        op8(1'b1, 8'h07, 8'hFD, 16'hFFEB, 1'b1, 4);
        op8(1'b0, 8'h0D, 8'h0B, 16'h008F, 1'b0, 5);

        // Asynchronous reset in the middle of a calculation.
        wait_idle8();
        start8 = 1'b1; sm8 = 1'b1; a8 = 8'h7F; b8 = 8'h7F;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset busy8", {31'h0, busy8}, 32'h0);
        check("midreset done8", {31'h0, done8}, 32'h0);
        check("midreset product8", {16'h0, prod8}, 32'h0);
        check("midreset negative8", {31'h0, neg8}, 32'h0);
        check("midreset busy8n", {31'h0, busy8n}, 32'h0);
        check("midreset product8n", {16'h0, prod8n}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        op8(1'b1, 8'hF6, 8'h0C, 16'hFF88, 1'b1, 5);

        for (int i = 0; i < 300; i++) begin
            sm = 1'($urandom_range(0, 1));
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (sm) p8 = $signed({{8{ra[7]}}, ra}) * $signed({{8{rb[7]}}, rb});
            else    p8 = $signed({8'h0, ra} * {8'h0, rb});
            op8(sm, ra, rb, p8, sm & p8[15],
                lat_ee(sm ? longint'($signed(ra)) : longint'(ra)));
        end

        op16(1'b1, 16'h8000, 16'h7FFF, 32'hC0008000, 1'b1, 17);
        op16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0, 17);
        for (int i = 0; i < 100; i++) begin
            sm = 1'($urandom_range(0, 1));
            wa = 16'($urandom);
            wb = 16'($urandom);
            if (sm) p16 = $signed({{16{wa[15]}}, wa}) * $signed({{16{wb[15]}}, wb});
            else    p16 = $signed({16'h0, wa} * {16'h0, wb});
            op16(sm, wa, wb, p16, sm & p16[31],
                 lat_ee(sm ? longint'($signed(wa)) : longint'(wa)));
        end

        t = 0;
        while ((q8.size() + q8n.size() + q16.size()) > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("pending results", 32'(q8.size() + q8n.size() + q16.size()), 32'h0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
